// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
//   Hazard controller for the five-stage RV32I pipeline.
//   Drives the stage stall/flush enables and the execute-stage forwarding
//   selects. Sequences multi-cycle data-memory accesses with a watchdog, and
//   counts stalled cycles (saturating) for performance debug.
//
// Ports
//   clk_i, rst_i                   clock (rising edge), async active-high reset
//   rs1D_i, rs2D_i                 decode-stage source registers
//   rs1E_i, rs2E_i                 execute-stage source registers
//   rdE_i, rdM_i, rdW_i            destination registers in E/M/W
//   result_srcE_i                  instruction in E is a load
//   pc_srcE_i                      taken branch/jump resolved in E
//   reg_writeM_i, reg_writeW_i     register write enables in M/W
//   mem_accessM_i, mem_ready_i     load/store in M, memory completes this cycle
//   mem_req_o                      data memory request
//   stallF_o..stallM_o             hold the stage register
//   flushD_o, flushE_o, flushW_o   clear the stage register to a bubble
//   forward_aE_o, forward_bE_o     00 regfile, 01 W result, 10 M ALU result
//   mem_timeout_o                  sticky watchdog error
//   stall_cycles_o                 saturating count of cycles with stallF_o
// ============================================================================
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT        = 256,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
    input  logic                      result_srcE_i,
    input  logic                      pc_srcE_i,
    input  logic                      reg_writeM_i,
    input  logic                      reg_writeW_i,
    input  logic                      mem_accessM_i,
    input  logic                      mem_ready_i,
    output logic                      mem_req_o,
    output logic                      stallF_o,
    output logic                      stallD_o,
    output logic                      stallE_o,
    output logic                      stallM_o,
    output logic                      flushD_o,
    output logic                      flushE_o,
    output logic                      flushW_o,
    output logic [1:0]                forward_aE_o,
    output logic [1:0]                forward_bE_o,
    output logic                      mem_timeout_o,
    output logic [CNT_WIDTH-1:0]      stall_cycles_o
);

    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [WC_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    logic mem_pending;
    logic mem_stall;
    logic lw_stall;

    // Operand select: M result has priority over W; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
        if (reg_writeM_i && (rdM_i != '0) && (rdM_i == rs)) begin
            return 2'b10;
        end else if (reg_writeW_i && (rdW_i != '0) && (rdW_i == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign mem_pending = mem_accessM_i & ~mem_ready_i;
    // Once the watchdog trips the core stays frozen until reset.
    assign mem_stall   = timeout_q | mem_pending;
    assign lw_stall    = result_srcE_i & (rdE_i != '0) &
                         ((rdE_i == rs1D_i) | (rdE_i == rs2D_i));

    always_comb begin
        stallF_o     = 1'b0;
        stallD_o     = 1'b0;
        stallE_o     = 1'b0;
        stallM_o     = 1'b0;
        flushD_o     = 1'b0;
        flushE_o     = 1'b0;
        flushW_o     = 1'b0;
        mem_req_o    = 1'b0;
        forward_aE_o = 2'b00;
        forward_bE_o = 2'b00;
        if (rst_i) begin
            flushD_o = 1'b1;
            flushE_o = 1'b1;
            flushW_o = 1'b1;
        end else begin
            forward_aE_o = fwd_sel(rs1E_i);
            forward_bE_o = fwd_sel(rs2E_i);
            mem_req_o    = mem_accessM_i & ~timeout_q;
            if (mem_stall) begin
                // Load-use and branch actions wait: D/E contents are frozen
                // and get re-evaluated on the release cycle.
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                stallE_o = 1'b1;
                stallM_o = 1'b1;
                flushW_o = 1'b1;
            end else if (pc_srcE_i) begin
                // No F stall here so the branch target loads into PC.
                flushD_o = 1'b1;
                flushE_o = 1'b1;
            end else if (lw_stall) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                flushE_o = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mem_pending && !timeout_q) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_pending) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WC_LAST) begin
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            if (stallF_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign mem_timeout_o  = timeout_q;
    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int AW  = 5;
    localparam int TO  = 4;
    localparam int CW  = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i;
    logic          result_srcE_i, pc_srcE_i, reg_writeM_i, reg_writeW_i;
    logic          mem_accessM_i, mem_ready_i;
    logic          mem_req_o, stallF_o, stallD_o, stallE_o, stallM_o;
    logic          flushD_o, flushE_o, flushW_o, mem_timeout_o;
    logic [1:0]    forward_aE_o, forward_bE_o;
    logic [CW-1:0] stall_cycles_o;

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rs1D_i(rs1D_i), .rs2D_i(rs2D_i), .rs1E_i(rs1E_i), .rs2E_i(rs2E_i),
        .rdE_i(rdE_i), .rdM_i(rdM_i), .rdW_i(rdW_i),
        .result_srcE_i(result_srcE_i), .pc_srcE_i(pc_srcE_i),
        .reg_writeM_i(reg_writeM_i), .reg_writeW_i(reg_writeW_i),
        .mem_accessM_i(mem_accessM_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_o),
        .stallF_o(stallF_o), .stallD_o(stallD_o), .stallE_o(stallE_o), .stallM_o(stallM_o),
        .flushD_o(flushD_o), .flushE_o(flushE_o), .flushW_o(flushW_o),
        .forward_aE_o(forward_aE_o), .forward_bE_o(forward_bE_o),
        .mem_timeout_o(mem_timeout_o), .stall_cycles_o(stall_cycles_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: stalled-cycle tally, sticky watchdog flag and
    // the length of the current run of unanswered memory cycles.
    int cnt_m;
    bit to_m;
    int consec_m;

    // Expected combinational outputs.
    bit       e_req, e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fW;
    bit [1:0] e_fa, e_fb;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit [1:0] fwd_m(input logic [AW-1:0] rs);
        if (reg_writeM_i && rdM_i != 0 && rdM_i == rs) return 2'd2;
        if (reg_writeW_i && rdW_i != 0 && rdW_i == rs) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_reset();
        cnt_m = 0; to_m = 0; consec_m = 0;
    endtask

    task automatic compute();
        bit mst, lw;
        {e_req, e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fW} = '0;
        e_fa = 0; e_fb = 0;
        mst = to_m || (mem_accessM_i && !mem_ready_i);
        lw  = result_srcE_i && rdE_i != 0 && (rdE_i == rs1D_i || rdE_i == rs2D_i);
        if (rst_i) begin
            e_fD = 1; e_fE = 1; e_fW = 1;
        end else begin
            e_fa  = fwd_m(rs1E_i);
            e_fb  = fwd_m(rs2E_i);
            e_req = mem_accessM_i && !to_m;
            if (mst) begin
                e_sF = 1; e_sD = 1; e_sE = 1; e_sM = 1; e_fW = 1;
            end else if (pc_srcE_i) begin
                e_fD = 1; e_fE = 1;
            end else if (lw) begin
                e_sF = 1; e_sD = 1; e_fE = 1;
            end
        end
    endtask

    task automatic check_all();
        compute();
        check("mem_req", mem_req_o, e_req);
        check("stallF", stallF_o, e_sF);
        check("stallD", stallD_o, e_sD);
        check("stallE", stallE_o, e_sE);
        check("stallM", stallM_o, e_sM);
        check("flushD", flushD_o, e_fD);
        check("flushE", flushE_o, e_fE);
        check("flushW", flushW_o, e_fW);
        check("fwdA", forward_aE_o, e_fa);
        check("fwdB", forward_bE_o, e_fb);
        check("timeout", mem_timeout_o, to_m);
        check("stall_cycles", stall_cycles_o, cnt_m);
    endtask

    // Called at posedge+1: updates the model across the next rising edge.
    task automatic advance();
        compute();
        @(posedge clk_i);
        if (rst_i) begin
            model_reset();
        end else begin
            if (e_sF && cnt_m < CNT_MAX) cnt_m++;
            if (mem_accessM_i && !mem_ready_i) consec_m++;
            else consec_m = 0;
            // The first unanswered cycle plus TO watchdog cycles trips it.
            if (consec_m >= TO + 1) to_m = 1;
        end
        #1;
    endtask

    task automatic cyc();
        #1;
        check_all();
        advance();
        $display("cycle t=%0t acc=%0b rdy=%0b pc=%0b stallF=%0b fwd=%0d/%0d cnt=%0d to=%0b",
                 $time, mem_accessM_i, mem_ready_i, pc_srcE_i, stallF_o,
                 forward_aE_o, forward_bE_o, stall_cycles_o, mem_timeout_o);
    endtask

    task automatic zero_in();
        {rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i} = '0;
        {result_srcE_i, pc_srcE_i, reg_writeM_i, reg_writeW_i} = '0;
        mem_accessM_i = 0; mem_ready_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1; model_reset();
        #1 check_all();
        advance();
        cyc();
        rst_i = 0;
    endtask

    initial begin
        int nreq, nst;
        zero_in();
        rst_i = 1;
        model_reset();
        @(posedge clk_i); #1;
        do_reset();
        check("reset_cnt", stall_cycles_o, 0);

        // Forwarding priority
        rs1E_i = 5; rdM_i = 5; reg_writeM_i = 1; rdW_i = 5; reg_writeW_i = 1;
        #1 check("fwdA_M", forward_aE_o, 2'b10);
        cyc();
        reg_writeM_i = 0;
        #1 check("fwdA_W", forward_aE_o, 2'b01);
        cyc();
        rdM_i = 0; rdW_i = 0; reg_writeM_i = 1;
        #1 check("fwdA_x0", forward_aE_o, 2'b00);
        cyc();
        zero_in();

        // Load-use: single cycle stall
        result_srcE_i = 1; rdE_i = 7; rs2D_i = 7;
        #1 check("lu_stallF", stallF_o, 1);
        check("lu_flushE", flushE_o, 1);
        cyc();
        check("lu_cnt", stall_cycles_o, 1);

        // Branch wins over load-use
        pc_srcE_i = 1;
        #1 check("br_stallF", stallF_o, 0);
        check("br_flushD", flushD_o, 1);
        cyc();
        check("br_cnt", stall_cycles_o, 1);
        zero_in();

        // Memory wait: ready after 3 cycles
        nreq = 0; nst = 0;
        mem_accessM_i = 1;
        for (int i = 0; i < 4; i++) begin
            mem_ready_i = (i == 3);
            #1 check_all();
            if (mem_req_o) nreq++;
            if (stallF_o && flushW_o && stallM_o) nst++;
            advance();
        end
        mem_accessM_i = 0; mem_ready_i = 0;
        check("mw_req_cycles", nreq, 4);
        check("mw_stall_cycles", nst, 3);
        check("mw_cnt", stall_cycles_o, 4);
        // Zero-wait access right after: no stall, FSM back in RUN
        mem_accessM_i = 1; mem_ready_i = 1;
        #1 check("zw_stallF", stallF_o, 0);
        cyc();
        zero_in();

        // Randomized traffic (watchdog kept from tripping)
        for (int n = 0; n < 300; n++) begin
            rs1D_i = AW'($urandom_range(0, 3)); rs2D_i = AW'($urandom_range(0, 3));
            rs1E_i = AW'($urandom_range(0, 3)); rs2E_i = AW'($urandom_range(0, 3));
            rdE_i  = AW'($urandom_range(0, 3)); rdM_i  = AW'($urandom_range(0, 3));
            rdW_i  = AW'($urandom_range(0, 3));
            result_srcE_i = 1'($urandom_range(0, 1));
            pc_srcE_i     = ($urandom_range(0, 3) == 0);
            reg_writeM_i  = 1'($urandom_range(0, 1));
            reg_writeW_i  = 1'($urandom_range(0, 1));
            mem_accessM_i = 1'($urandom_range(0, 1));
            mem_ready_i   = (consec_m >= TO - 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
            cyc();
        end
        check("sat_cnt", stall_cycles_o, CNT_MAX);
        zero_in();

        // Watchdog
        do_reset();
        mem_accessM_i = 1; mem_ready_i = 0;
        for (int i = 0; i < TO; i++) cyc();
        check("wd_not_yet", mem_timeout_o, 0);
        cyc();
        check("wd_timeout", mem_timeout_o, 1);
        #1 check("wd_req", mem_req_o, 0);
        check("wd_stall", stallF_o, 1);
        mem_ready_i = 1;
        cyc();
        check("wd_sticky", mem_timeout_o, 1);
        zero_in();
        do_reset();
        check("wd_cleared", mem_timeout_o, 0);

        // Asynchronous reset in the middle of a wait
        mem_accessM_i = 1; mem_ready_i = 0;
        cyc(); cyc();
        #2 rst_i = 1; model_reset();
        #1 check("mid_flushD", flushD_o, 1);
        check("mid_stallF", stallF_o, 0);
        check("mid_req", mem_req_o, 0);
        check("mid_cnt", stall_cycles_o, 0);
        @(negedge clk_i);
        zero_in();
        rst_i = 0;
        @(posedge clk_i); #1;
        check_all();
        mem_accessM_i = 1; mem_ready_i = 1;
        cyc();
        mem_ready_i = 0;
        for (int i = 0; i < TO; i++) cyc();
        check("mid_rerun_to", mem_timeout_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
